// File: rtl/s2p_pkg.sv
// Shared constants for the serial-to-parallel receiver: default COM symbol,
// word width, FSM state encoding and a helper that sizes the bit counter.
// Imported by rx_shift_reg and serial_to_parallel_rx.
package s2p_pkg;

    localparam int unsigned WIDTH_DEF   = 8;
    localparam logic [7:0]  COM_SYM_DEF = 8'hBC;

    // Alignment state: hunting for a COM, confirming COM spacing, locked to words
    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Bits needed to count 0..w-1 inside a word
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned BIT_CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/rx_shift_reg.sv
// WIDTH-bit serial-in/parallel-out shift register, MSB first, async active-low clear.
// Latency: nsr_o is the combinational next value; sr_o is the registered value.
// No backpressure: shifts one bit on every rising clock edge.
module rx_shift_reg
    import s2p_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             data_i,
    output logic [WIDTH-1:0] sr_o,
    output logic [WIDTH-1:0] nsr_o
);

    logic [WIDTH-1:0] sr_q;

    // Newest bit enters at the LSB so the first bit of a word ends up as its MSB
    assign nsr_o = {sr_q[WIDTH-2:0], data_i};
    assign sr_o  = sr_q;

    // Shift every edge; reset clears the whole register immediately
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= nsr_o;
        end
    end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Serial receiver: hunts COM symbols to find word alignment, then emits each received word.
// Latency: word visible right after the edge that samples its last bit; all outputs registered.
// No backpressure: consumes one bit per dclk edge. Optional macro S2P_COM_CNT_EN adds com_count.
module serial_to_parallel_rx
    import s2p_pkg::*;
#(
    parameter int unsigned      WIDTH     = WIDTH_DEF,
    parameter logic [WIDTH-1:0] COM_SYM   = COM_SYM_DEF,
    parameter int unsigned      LOCK_COMS = 4
) (
    input  logic             dclk,
    input  logic             reset_L,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             word_stb,
    output logic             active
`ifdef S2P_COM_CNT_EN
    ,
    output logic [15:0]      com_count
`endif
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] nsr;

    state_e           state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [3:0]       coms_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             stb_q;
    logic             active_q;

    logic             is_com;
    logic             at_boundary;
    logic             coms_hit;
    logic [CNT_W-1:0] bit_cnt_inc;

    rx_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk_i  (dclk),
        .rst_ni (reset_L),
        .data_i (data_in),
        .sr_o   (sr),
        .nsr_o  (nsr)
    );

    // Full shift-register contents are only consumed via nsr
    logic unused_sr;
    assign unused_sr = ^sr;

    // Word-boundary and COM decode on the value the shift register is about to hold
    always_comb begin
        is_com      = (nsr == COM_SYM);
        at_boundary = (bit_cnt_q == CNT_W'(WIDTH - 1));
        bit_cnt_inc = at_boundary ? '0 : bit_cnt_q + CNT_W'(1);
        coms_hit    = (({1'b0, coms_q} + 5'd1) == 5'(LOCK_COMS));
    end

    // Alignment FSM with registered word outputs; only reset leaves LOCKED
    always_ff @(posedge dclk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= ST_SEARCH;
            bit_cnt_q <= '0;
            coms_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            stb_q     <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            case (state_q)
                ST_SEARCH: begin
                    // Any bit position may start a COM; the edge that completes one defines the boundary
                    if (is_com) begin
                        state_q   <= ST_ALIGN;
                        bit_cnt_q <= '0;
                        coms_q    <= 4'd1;
                    end
                end
                ST_ALIGN: begin
                    bit_cnt_q <= bit_cnt_inc;
                    if (at_boundary) begin
                        if (is_com && coms_hit) begin
                            // The locking COM is reported as the first (non-payload) word
                            state_q   <= ST_LOCKED;
                            bit_cnt_q <= '0;
                            data_q    <= COM_SYM;
                            valid_q   <= 1'b0;
                            stb_q     <= 1'b1;
                            active_q  <= 1'b1;
                        end else if (is_com) begin
                            coms_q <= coms_q + 4'd1;
                        end else begin
                            // Misaligned word is dropped; hunting restarts on the following bits
                            state_q <= ST_SEARCH;
                            coms_q  <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    bit_cnt_q <= bit_cnt_inc;
                    if (at_boundary) begin
                        data_q  <= nsr;
                        valid_q <= !is_com;
                        stb_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_SEARCH;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign word_stb  = stb_q;
    assign active    = active_q;

`ifdef S2P_COM_CNT_EN
    logic [15:0] com_cnt_q;
    logic [15:0] com_cnt_d;
    logic        com_evt;

    // A COM word is counted when it is reported: at lock and at every locked boundary
    always_comb begin
        com_evt = is_com && at_boundary &&
                  ((state_q == ST_LOCKED) || ((state_q == ST_ALIGN) && coms_hit));
        com_cnt_d = com_cnt_q;
        if (com_evt && (com_cnt_q != 16'hFFFF)) begin
            com_cnt_d = com_cnt_q + 16'd1;
        end
    end

    // Saturating COM word counter
    always_ff @(posedge dclk or negedge reset_L) begin
        if (!reset_L) begin
            com_cnt_q <= '0;
        end else begin
            com_cnt_q <= com_cnt_d;
        end
    end

    assign com_count = com_cnt_q;
`endif

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx: reset, lock, payload, mid-word reset,
// broken alignment, end-to-end through a behavioural COM-inserter/serializer,
// and the optional COM counter (S2P_COM_CNT_EN).
module tb_serial_to_parallel_rx;

    logic       dclk    = 1'b0;
    logic       reset_L = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       word_stb;
    logic       active;
`ifdef S2P_COM_CNT_EN
    logic [15:0] com_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    serial_to_parallel_rx dut (
        .dclk      (dclk),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .word_stb  (word_stb),
        .active    (active)
`ifdef S2P_COM_CNT_EN
        ,
        .com_count (com_count)
`endif
    );

    always #5 dclk = ~dclk;

    // Present one bit, let the DUT sample it, then settle 1 time unit past the edge
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge dclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic apply_reset();
        @(negedge dclk);
        reset_L = 1'b0;
        @(negedge dclk);
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        reset_L = 1'b0;
        #1;
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", data_out); end
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        n_cmp++; if (word_stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb: got %b want 0", word_stb); end
        n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL reset_active: got %b want 0", active); end
        @(negedge dclk);
        @(negedge dclk);
        reset_L = 1'b1;
    endtask

    task automatic test_lock();
        logic [34:0] stream;
        int early_stb;
        stream = {3'b101, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
        early_stb = 0;
        for (int i = 34; i >= 1; i--) begin
            send_bit(stream[i]);
            if (word_stb) early_stb++;
        end
        n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL lock_active_early: got %b want 0 at bit 34", active); end
        n_cmp++; if (early_stb !== 0) begin n_bad++; $display("FAIL lock_stb_early: got %0d strobes want 0", early_stb); end
        send_bit(stream[0]);
        n_cmp++; if (active !== 1'b1) begin n_bad++; $display("FAIL lock_active: got %b want 1", active); end
        n_cmp++; if (word_stb !== 1'b1) begin n_bad++; $display("FAIL lock_stb: got %b want 1", word_stb); end
        n_cmp++; if (data_out !== 8'hBC) begin n_bad++; $display("FAIL lock_data: got %h want bc", data_out); end
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL lock_valid: got %b want 0", valid_out); end
    endtask

    task automatic test_payload();
        logic [7:0] bytes [4];
        logic       vexp  [4];
        int         stb_mid;
        bytes = '{8'h5A, 8'hFF, 8'hBC, 8'h00};
        vexp  = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int w = 0; w < 4; w++) begin
            stb_mid = 0;
            for (int i = 7; i >= 1; i--) begin
                send_bit(bytes[w][i]);
                if (word_stb) stb_mid++;
            end
            send_bit(bytes[w][0]);
            n_cmp++; if (stb_mid !== 0) begin n_bad++; $display("FAIL payload_stb_mid[%0d]: got %0d want 0", w, stb_mid); end
            n_cmp++; if (word_stb !== 1'b1) begin n_bad++; $display("FAIL payload_stb[%0d]: got %b want 1", w, word_stb); end
            n_cmp++; if (data_out !== bytes[w]) begin n_bad++; $display("FAIL payload_data[%0d]: got %h want %h", w, data_out, bytes[w]); end
            n_cmp++; if (valid_out !== vexp[w]) begin n_bad++; $display("FAIL payload_valid[%0d]: got %b want %b", w, valid_out, vexp[w]); end
        end
    endtask

    task automatic test_reset_midword();
        logic [31:0] coms;
        send_byte(8'h5A);
        n_cmp++; if (data_out !== 8'h5A) begin n_bad++; $display("FAIL midrst_pre_data: got %h want 5a", data_out); end
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        #2;
        reset_L = 1'b0;
        #1;
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL midrst_data: got %h want 00", data_out); end
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", valid_out); end
        n_cmp++; if (word_stb !== 1'b0) begin n_bad++; $display("FAIL midrst_stb: got %b want 0", word_stb); end
        n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL midrst_active: got %b want 0", active); end
        @(negedge dclk);
        reset_L = 1'b1;
        coms = {4{8'hBC}};
        for (int i = 31; i >= 1; i--) send_bit(coms[i]);
        n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL relock_early: got %b want 0 at bit 31", active); end
        send_bit(coms[0]);
        n_cmp++; if (active !== 1'b1) begin n_bad++; $display("FAIL relock_active: got %b want 1", active); end
        n_cmp++; if (data_out !== 8'hBC) begin n_bad++; $display("FAIL relock_data: got %h want bc", data_out); end
    endtask

    task automatic test_broken_align();
        logic [55:0] stream;
        int first_active;
        int stb_cnt;
        apply_reset();
        stream = {8'hBC, 8'hBC, 8'h00, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
        first_active = -1;
        stb_cnt = 0;
        for (int i = 55; i >= 0; i--) begin
            send_bit(stream[i]);
            if (word_stb) stb_cnt++;
            if (active && first_active < 0) first_active = 56 - i;
        end
        n_cmp++; if (first_active !== 56) begin n_bad++; $display("FAIL broken_lock_edge: got %0d want 56", first_active); end
        n_cmp++; if (stb_cnt !== 1) begin n_bad++; $display("FAIL broken_stb_count: got %0d want 1", stb_cnt); end
    endtask

    task automatic test_end_to_end();
        logic [7:0] bytes [10];
        logic       vld   [10];
        logic [7:0] exp_q [$];
        logic [7:0] got_q [$];
        logic [7:0] word;
        apply_reset();
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hA5};
        vld   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        // Idle link: TX sends COM words while its valid is low
        for (int s = 0; s < 5; s++) send_byte(8'hBC);
        for (int s = 0; s < 10; s++) begin
            word = vld[s] ? bytes[s] : 8'hBC;
            if (vld[s]) exp_q.push_back(bytes[s]);
            for (int i = 7; i >= 0; i--) begin
                send_bit(word[i]);
                if (word_stb && valid_out) got_q.push_back(data_out);
            end
        end
        n_cmp++; if (got_q.size() !== 6) begin n_bad++; $display("FAIL e2e_count: got %0d want 6", got_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (k >= got_q.size()) begin
                n_bad++; $display("FAIL e2e_byte[%0d]: got none want %h", k, exp_q[k]);
            end else if (got_q[k] !== exp_q[k]) begin
                n_bad++; $display("FAIL e2e_byte[%0d]: got %h want %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

`ifdef S2P_COM_CNT_EN
    task automatic test_com_count();
        apply_reset();
        n_cmp++; if (com_count !== 16'h0000) begin n_bad++; $display("FAIL comcnt_reset: got %h want 0000", com_count); end
        for (int s = 0; s < 4; s++) send_byte(8'hBC);
        n_cmp++; if (com_count !== 16'd1) begin n_bad++; $display("FAIL comcnt_lock: got %0d want 1", com_count); end
        for (int s = 0; s < 6; s++) send_byte(8'hBC);
        send_byte(8'h5A);
        n_cmp++; if (com_count !== 16'd7) begin n_bad++; $display("FAIL comcnt_seven: got %0d want 7", com_count); end
        @(negedge dclk);
        force dut.com_cnt_q = 16'hFFFE;
        #1;
        release dut.com_cnt_q;
        send_byte(8'hBC);
        n_cmp++; if (com_count !== 16'hFFFF) begin n_bad++; $display("FAIL comcnt_max: got %h want ffff", com_count); end
        send_byte(8'hBC);
        n_cmp++; if (com_count !== 16'hFFFF) begin n_bad++; $display("FAIL comcnt_sat: got %h want ffff", com_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_lock();
        test_payload();
        test_reset_midword();
        test_broken_align();
        test_end_to_end();
`ifdef S2P_COM_CNT_EN
        test_com_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
